// File: rtl/lcd_msg_arbiter.sv
// lcd_msg_arbiter
//   Shares one 16x2 character LCD between N_REQ message sources. A round-robin
//   arbiter picks a requester, latches its two 128-bit ASCII lines onto the
//   driver inputs, pulses drv_start, waits for the driver refresh to finish and
//   then keeps the message on screen for HOLD_CYCLES before arbitrating again.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   req          per-requester display request (level)
//   msg_first    line 1 per requester, requester i owns [i*128 +: 128]
//   msg_second   line 2 per requester, same packing
//   grant        one-hot, one-cycle pulse when a message is latched
//   active_id    index of the requester being served or held
//   busy         high in every state except IDLE
//   first_line   registered line 1 to the driver
//   second_line  registered line 2 to the driver
//   drv_start    one-cycle pulse launching a driver refresh
//   drv_busy     driver refresh in progress
//   state_dbg    current FSM state (IDLE=0 START=1 WAIT_ACK=2 WAIT_DONE=3 HOLD=4)
//
// Handshake with the driver: drv_start is a single-cycle request; the driver
// acknowledges by raising drv_busy and signals completion by lowering it. While
// drv_busy is high in IDLE (driver self-init) no arbitration takes place.
module lcd_msg_arbiter #(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*128-1:0] msg_first,
  input  logic [N_REQ*128-1:0] msg_second,
  output logic [N_REQ-1:0]     grant,
  output logic [2:0]           active_id,
  output logic                 busy,
  output logic [127:0]         first_line,
  output logic [127:0]         second_line,
  output logic                 drv_start,
  input  logic                 drv_busy,
  output logic [2:0]           state_dbg
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] WAIT_ACK  = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] HOLD      = 3'd4;

  localparam logic [127:0]     SPACES    = {16{8'h20}};
  localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);

  logic [2:0]       state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;

  // Requests padded to 8 so the 3-bit winner index addresses them exactly.
  logic [7:0]   req_pad;
  logic [2:0]   cand;
  logic         win_found;
  logic [2:0]   win_id;
  logic [7:0]   win_onehot;
  logic [127:0] win_first;
  logic [127:0] win_second;
  logic [2:0]   ptr_next;

  assign req_pad   = 8'(req);
  assign state_dbg = state;

  // Round-robin scan: first set request at ptr, ptr+1, ... wrapping at N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = 3'd0;
    cand      = 3'd0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = 3'((int'(ptr) + k) % N_REQ);
      if (!win_found && req_pad[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    win_onehot = 8'd1 << win_id;
    win_first  = msg_first[127:0];
    win_second = msg_second[127:0];
    for (int i = 0; i < N_REQ; i++) begin
      if (win_id == 3'(i)) begin
        win_first  = msg_first[i*128 +: 128];
        win_second = msg_second[i*128 +: 128];
      end
    end
  end

  // The requester just served moves to the back of the queue.
  assign ptr_next = (active_id == 3'(N_REQ - 1)) ? 3'd0 : active_id + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      drv_start   <= 1'b0;
      busy        <= 1'b0;
      active_id   <= 3'd0;
      ptr         <= 3'd0;
      hold_cnt    <= '0;
      first_line  <= SPACES;
      second_line <= SPACES;
    end else begin
      grant     <= '0;
      drv_start <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found && !drv_busy) begin
            grant       <= win_onehot[N_REQ-1:0];
            first_line  <= win_first;
            second_line <= win_second;
            active_id   <= win_id;
            busy        <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          drv_start <= 1'b1;
          state     <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (drv_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!drv_busy) begin
            if (HOLD_CYCLES == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
              ptr   <= ptr_next;
            end else begin
              hold_cnt <= HOLD_LOAD;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            ptr   <= ptr_next;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Bench for lcd_msg_arbiter with N_REQ=4, HOLD_CYCLES=4. A small driver model
// raises drv_busy two cycles after each drv_start and holds it for ten cycles.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_lcd_msg_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 4;
  localparam int REC_W = 4 + 3 + 256;
  localparam logic [2:0]   S_IDLE     = 3'd0;
  localparam logic [2:0]   S_WAIT_ACK = 3'd2;
  localparam logic [2:0]   S_HOLD     = 3'd4;
  localparam logic [127:0] SPACES     = {16{8'h20}};
  // Grant every 19 cycles: grant, START, refresh (2 + 10 model cycles),
  // WAIT_DONE exit, 4 hold cycles, 1 IDLE cycle.
  localparam int RR_PERIOD = 19;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*128-1:0] msg_first;
  logic [N*128-1:0] msg_second;
  logic [N-1:0]   grant;
  logic [2:0]     active_id;
  logic           busy;
  logic [127:0]   first_line;
  logic [127:0]   second_line;
  logic           drv_start;
  logic           drv_busy;
  logic [2:0]     state_dbg;
  logic           model_busy;
  logic           init_busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [REC_W-1:0] exp_q[$];

  assign drv_busy = model_busy | init_busy;

  lcd_msg_arbiter #(.N_REQ(N), .HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .msg_first(msg_first), .msg_second(msg_second),
    .grant(grant), .active_id(active_id), .busy(busy), .first_line(first_line),
    .second_line(second_line), .drv_start(drv_start), .drv_busy(drv_busy),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- driver model ----------------
  initial begin
    model_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (drv_start === 1'b1) begin
        repeat (2) @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [127:0] line_of(int i, bit second);
    if (second) return {"REQ", 8'(48 + i), " LINE TWO   "};
    return {"REQ", 8'(48 + i), " LINE ONE   "};
  endfunction

  function automatic logic [REC_W-1:0] mk_rec(logic [3:0] g, logic [2:0] id,
                                               logic [127:0] l1, logic [127:0] l2);
    return {g, id, l1, l2};
  endfunction

  // Waits (bounded) for a grant pulse and returns what the DUT showed with it.
  task automatic wait_grant(input int budget, output bit ok, output logic [REC_W-1:0] got);
    ok  = 1'b0;
    got = '0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (grant !== 4'b0000) begin
        ok  = 1'b1;
        got = {grant, active_id, first_line, second_line};
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int starts;
    int busy_hi;
    rst = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    checks++; if (first_line !== SPACES) begin errors++; $display("FAIL reset_first_line got=%h exp=%h", first_line, SPACES); end
    checks++; if (second_line !== SPACES) begin errors++; $display("FAIL reset_second_line got=%h exp=%h", second_line, SPACES); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (drv_start !== 1'b0) begin errors++; $display("FAIL reset_drv_start got=%b exp=0", drv_start); end
    checks++; if (active_id !== 3'd0) begin errors++; $display("FAIL reset_active_id got=%0d exp=0", active_id); end
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, S_IDLE); end
    rst = 1'b0;
    starts  = 0;
    busy_hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (drv_start !== 1'b0) starts++;
      if (busy !== 1'b0) busy_hi++;
    end
    checks++; if (starts != 0) begin errors++; $display("FAIL idle_no_start got=%0d pulses exp=0", starts); end
    checks++; if (busy_hi != 0) begin errors++; $display("FAIL idle_no_busy got=%0d cycles exp=0", busy_hi); end
  endtask

  task automatic test_single();
    bit ok;
    logic [REC_W-1:0] got;
    logic [REC_W-1:0] exp;
    int starts;
    int t_fall;
    int t_idle;
    bit seen_busy;
    exp_q.push_back(mk_rec(4'b0100, 3'd2, line_of(2, 0), line_of(2, 1)));
    req = 4'b0100;
    wait_grant(30, ok, got);
    req = 4'b0000;
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL single_grant ok=%0b got g=%b id=%0d l1=%h exp g=%b id=%0d l1=%h",
               ok, got[262:259], got[258:256], got[255:128], exp[262:259], exp[258:256], exp[255:128]);
    end
    @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_grant_width got=%b exp=0000", grant); end
    starts    = (drv_start === 1'b1) ? 1 : 0;
    t_fall    = -1;
    t_idle    = -1;
    seen_busy = 1'b0;
    for (int i = 0; i < 60 && t_idle < 0; i++) begin
      @(negedge clk);
      if (drv_start === 1'b1) starts++;
      if (drv_busy === 1'b1) seen_busy = 1'b1;
      if (seen_busy && drv_busy === 1'b0 && t_fall < 0) t_fall = cyc;
      if (busy === 1'b0) t_idle = cyc;
    end
    checks++; if (starts != 1) begin errors++; $display("FAIL single_start_pulses got=%0d exp=1", starts); end
    // One cycle for WAIT_DONE to see drv_busy low, then HOLD cycles.
    checks++; if (t_fall < 0 || t_idle - t_fall != HOLD + 1) begin errors++; $display("FAIL single_hold_len got=%0d exp=%0d", t_idle - t_fall, HOLD + 1); end
    checks++; if (first_line !== line_of(2, 0)) begin errors++; $display("FAIL single_line_kept got=%h exp=%h", first_line, line_of(2, 0)); end
    checks++; if (active_id !== 3'd2) begin errors++; $display("FAIL single_active_id got=%0d exp=2", active_id); end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [REC_W-1:0] got;
    logic [REC_W-1:0] exp;
    int prev;
    int order[5] = '{0, 1, 2, 3, 0};
    pulse_reset();
    req = 4'b1111;
    foreach (order[k])
      exp_q.push_back(mk_rec(4'(1 << order[k]), 3'(order[k]), line_of(order[k], 0), line_of(order[k], 1)));
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(60, ok, got);
      if (k == 4) req = 4'b0000;
      exp = exp_q.pop_front();
      checks++;
      if (!ok || got !== exp) begin
        errors++;
        $display("FAIL rr_grant[%0d] ok=%0b got g=%b id=%0d exp g=%b id=%0d", k, ok, got[262:259], got[258:256], exp[262:259], exp[258:256]);
      end
      if (k > 0) begin
        checks++;
        if (cyc - prev != RR_PERIOD) begin errors++; $display("FAIL rr_period[%0d] got=%0d exp=%0d", k, cyc - prev, RR_PERIOD); end
      end
      prev = cyc;
    end
    wait_idle(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_idle got=timeout exp=idle"); end
  endtask

  task automatic test_fairness();
    bit ok;
    logic [REC_W-1:0] got;
    logic [REC_W-1:0] exp;
    int order[3] = '{0, 3, 0};
    foreach (order[k])
      exp_q.push_back(mk_rec(4'(1 << order[k]), 3'(order[k]), line_of(order[k], 0), line_of(order[k], 1)));
    req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      wait_grant(60, ok, got);
      if (k == 0) req = 4'b1001;
      if (k == 2) req = 4'b0000;
      exp = exp_q.pop_front();
      checks++;
      if (!ok || got !== exp) begin
        errors++;
        $display("FAIL fair_grant[%0d] ok=%0b got g=%b id=%0d exp g=%b id=%0d", k, ok, got[262:259], got[258:256], exp[262:259], exp[258:256]);
      end
    end
    wait_idle(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fair_idle got=timeout exp=idle"); end
  endtask

  task automatic test_msg_stable();
    bit ok;
    bit stable;
    logic [REC_W-1:0] got;
    logic [REC_W-1:0] exp;
    logic [127:0] new_line;
    new_line = "CHANGED LINE 1  ";
    exp_q.push_back(mk_rec(4'b0010, 3'd1, line_of(1, 0), line_of(1, 1)));
    req = 4'b0010;
    wait_grant(60, ok, got);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL stable_grant ok=%0b got g=%b l1=%h exp g=%b l1=%h", ok, got[262:259], got[255:128], exp[262:259], exp[255:128]);
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (drv_busy === 1'b1) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL stable_refresh got=timeout exp=drv_busy"); end
    msg_first[1*128 +: 128] = new_line;
    req = 4'b0000;
    stable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (first_line !== line_of(1, 0)) stable = 1'b0;
      if (busy === 1'b0) ok = 1'b1;
    end
    checks++; if (!stable) begin errors++; $display("FAIL stable_line got=%h exp=%h", first_line, line_of(1, 0)); end
    checks++; if (!ok) begin errors++; $display("FAIL stable_complete got=timeout exp=idle"); end
    exp_q.push_back(mk_rec(4'b0010, 3'd1, new_line, line_of(1, 1)));
    req = 4'b0010;
    wait_grant(60, ok, got);
    req = 4'b0000;
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL stable_relatch ok=%0b got l1=%h exp l1=%h", ok, got[255:128], exp[255:128]);
    end
    wait_idle(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stable_idle got=timeout exp=idle"); end
  endtask

  task automatic test_busy_block();
    bit ok;
    int grants;
    logic [REC_W-1:0] got;
    logic [REC_W-1:0] exp;
    init_busy = 1'b1;
    req = 4'b0100;
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (grant !== 4'b0000) grants++;
    end
    checks++; if (grants != 0) begin errors++; $display("FAIL block_no_grant got=%0d exp=0", grants); end
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL block_state got=%0d exp=%0d", state_dbg, S_IDLE); end
    exp_q.push_back(mk_rec(4'b0100, 3'd2, line_of(2, 0), line_of(2, 1)));
    init_busy = 1'b0;
    wait_grant(10, ok, got);
    req = 4'b0000;
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL block_release ok=%0b got g=%b id=%0d exp g=%b id=%0d", ok, got[262:259], got[258:256], exp[262:259], exp[258:256]);
    end
    wait_idle(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL block_idle got=timeout exp=idle"); end
  endtask

  task automatic test_reset_abort();
    bit ok;
    logic [REC_W-1:0] got;
    logic [REC_W-1:0] exp;
    logic [2:0] target[2] = '{S_HOLD, S_WAIT_ACK};
    logic [3:0] exp_g[2]  = '{4'b1000, 4'b0100};
    int         exp_id[2] = '{3, 2};
    req = 4'b1100;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(mk_rec(exp_g[r], 3'(exp_id[r]), line_of(exp_id[r], 0), line_of(exp_id[r], 1)));
      wait_grant(60, ok, got);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || got !== exp) begin
        errors++;
        $display("FAIL abort_grant[%0d] ok=%0b got g=%b id=%0d exp g=%b id=%0d", r, ok, got[262:259], got[258:256], exp[262:259], exp[258:256]);
      end
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
        if (state_dbg === target[r]) ok = 1'b1;
        else @(negedge clk);
      end
      checks++; if (!ok) begin errors++; $display("FAIL abort_reach[%0d] got=%0d exp=%0d", r, state_dbg, target[r]); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL abort_state[%0d] got=%0d exp=%0d", r, state_dbg, S_IDLE); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy[%0d] got=%b exp=0", r, busy); end
      checks++; if (first_line !== SPACES || second_line !== SPACES) begin errors++; $display("FAIL abort_lines[%0d] got=%h exp=%h", r, first_line, SPACES); end
      checks++; if (drv_start !== 1'b0) begin errors++; $display("FAIL abort_start[%0d] got=%b exp=0", r, drv_start); end
    end
    // After the WAIT_ACK abort ptr is 0 again, so requester 2 wins once more.
    exp_q.push_back(mk_rec(4'b0100, 3'd2, line_of(2, 0), line_of(2, 1)));
    wait_grant(60, ok, got);
    req = 4'b0000;
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL abort_regrant ok=%0b got g=%b id=%0d exp g=%b id=%0d", ok, got[262:259], got[258:256], exp[262:259], exp[258:256]);
    end
    wait_idle(80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_idle got=timeout exp=idle"); end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    rst       = 1'b1;
    req       = '0;
    init_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      msg_first[i*128 +: 128]  = line_of(i, 0);
      msg_second[i*128 +: 128] = line_of(i, 1);
    end
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_msg_stable();
    test_busy_block();
    test_reset_abort();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
